hazard_ctrl_fsm: RTL

- Central pipeline sequencing controller for the five-stage core.
- Owns the stall/flush enables consumed by fetch, IF/ID, decode and later stages:
  - load-use stall
  - taken-branch flush
  - data-memory wait freeze
  - post-reset pipeline purge
- Sits beside decode; hazard inputs come from the IF/ID and ID/EX registers.
- Also keeps saturating stall/flush performance counters.

---
 rtl/hazard_ctrl_fsm.sv | 125 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_fsm.sv
// Pipeline sequencing controller: load-use stall, branch flush, dmem freeze,
// post-reset purge, plus saturating stall/flush performance counters.
module hazard_ctrl_fsm #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IDEX_MemoryRead,
  input  logic [4:0]       IDEX_rd,
  input  logic [4:0]       IFID_rs1,
  input  logic [4:0]       IFID_rs2,
  input  logic             uses_rs2,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IF_flush,
  output logic             IDEX_bubble,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {INIT, RUN, FLUSH, MEM_WAIT} state_t;

  localparam logic [2:0] FLUSH_LEFT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t     state, state_nxt, eval_state;
  logic [2:0] flush_left, flush_left_nxt;
  logic       load_use;
  logic       flush_evt;

  always_comb begin
    load_use = IDEX_MemoryRead && (IDEX_rd != 5'd0) &&
               ((IDEX_rd == IFID_rs1) || (uses_rs2 && (IDEX_rd == IFID_rs2)));

    // The cycle dmem_busy drops in MEM_WAIT is decoded as the state being
    // resumed, so the pipeline restarts without an extra dead cycle.
    eval_state = state;
    if (state == MEM_WAIT && !dmem_busy)
      eval_state = (flush_left != 3'd0) ? FLUSH : RUN;

    PCWrite        = 1'b1;
    IFIDWrite      = 1'b1;
    IF_flush       = 1'b0;
    IDEX_bubble    = 1'b0;
    pipe_hold      = 1'b0;
    flush_evt      = 1'b0;
    state_nxt      = state;
    flush_left_nxt = flush_left;

    case (eval_state)
      INIT: begin
        PCWrite     = 1'b0;
        IFIDWrite   = 1'b0;
        IF_flush    = 1'b1;
        IDEX_bubble = 1'b1;
        state_nxt   = RUN;
      end
      RUN: begin
        state_nxt = RUN;
        if (dmem_busy) begin
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          pipe_hold = 1'b1;
          state_nxt = MEM_WAIT;
        end else if (load_use) begin
          PCWrite     = 1'b0;
          IFIDWrite   = 1'b0;
          IDEX_bubble = 1'b1;
        end else if (branch_taken) begin
          IF_flush  = 1'b1;
          flush_evt = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            flush_left_nxt = FLUSH_LEFT_INIT;
            state_nxt      = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (dmem_busy) begin
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          pipe_hold = 1'b1;
          state_nxt = MEM_WAIT;
        end else begin
          IF_flush       = 1'b1;
          flush_left_nxt = flush_left - 3'd1;
          state_nxt      = (flush_left <= 3'd1) ? RUN : FLUSH;
        end
      end
      MEM_WAIT: begin
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        pipe_hold = 1'b1;
        state_nxt = MEM_WAIT;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      flush_left <= '0;
    end else begin
      state      <= state_nxt;
      flush_left <= flush_left_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state != INIT && !PCWrite && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
